result_collector: RTL and testbench

- Sits directly downstream of the row-column multiplier.
- Owns the m x m result matrix and serves the multiplier's accumulator read-back (current_element) for the addressed entry.
- Accepts each partial/final result through the z_stb/z_ack handshake. Once the multiplier signals done, streams the finished matrix out in row-major order over a valid/ready interface.
- Replaces the bench-side result array and writer with synthesizable RTL.

---
 rtl/result_collector.sv | 145 ++++++++++++++
 tb/tb_result_collector.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Result matrix store for the row-column multiplier: collects results over the
// z_stb/z_ack handshake, then drains the finished matrix row-major over valid/ready.
module result_collector #(
    parameter int m     = 4,
    parameter int m_len = $clog2(m),
    parameter int W     = 32,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [W-1:0]     z_out,
    input  logic [m_len-1:0] z_i,
    input  logic [m_len-1:0] z_j,
    input  logic             z_stb,
    output logic             z_ack,
    output logic [W-1:0]     current_element,
    input  logic             mult_done,
    output logic [W-1:0]     out_data,
    output logic [m_len-1:0] out_i,
    output logic [m_len-1:0] out_j,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    wr_count,
    output logic             done
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int N = m * m;
    localparam logic [m_len-1:0] LAST = m_len'(m - 1);

    state_t              state_q, state_d;
    logic [W-1:0]        mem_q [N];
    logic [W-1:0]        mem_d [N];
    logic                z_ack_q, z_ack_d;
    logic [CW-1:0]       wr_count_q, wr_count_d;
    logic                out_valid_q, out_valid_d;
    logic [m_len-1:0]    out_i_q, out_i_d;
    logic [m_len-1:0]    out_j_q, out_j_d;
    logic [W-1:0]        out_data_q, out_data_d;
    logic [m_len-1:0]    next_i, next_j;

    // Matrix is addressed by concatenating row and column, so m must be a power of two.
    assign current_element = mem_q[{z_i, z_j}];

    always_comb begin
        next_i = out_i_q;
        next_j = out_j_q + 1'b1;
        if (out_j_q == LAST) begin
            next_i = out_i_q + 1'b1;
            next_j = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        z_ack_d     = 1'b0;
        wr_count_d  = wr_count_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_j_d     = out_j_q;
        out_data_d  = out_data_q;

        case (state_q)
            COLLECT: begin
                // A pending write always wins over the move to DRAIN.
                if (z_stb && !z_ack_q) begin
                    mem_d[{z_i, z_j}] = z_out;
                    z_ack_d           = 1'b1;
                    if (wr_count_q != {CW{1'b1}}) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                end else if (mult_done) begin
                    state_d     = DRAIN;
                    out_i_d     = '0;
                    out_j_d     = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[0];
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_i_q == LAST && out_j_q == LAST) begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        out_i_d    = next_i;
                        out_j_d    = next_j;
                        out_data_d = mem_q[{next_i, next_j}];
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (clear) begin
            state_d     = COLLECT;
            mem_d       = '{default: '0};
            z_ack_d     = 1'b0;
            wr_count_d  = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            mem_q       <= '{default: '0};
            z_ack_q     <= 1'b0;
            wr_count_q  <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_j_q     <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            z_ack_q     <= z_ack_d;
            wr_count_q  <= wr_count_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_j_q     <= out_j_d;
            out_data_q  <= out_data_d;
        end
    end

    assign z_ack     = z_ack_q;
    assign wr_count  = wr_count_q;
    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_j     = out_j_q;
    assign out_data  = out_data_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: a plain-array matrix model predicts
// every drained beat, and a negedge monitor checks beats as the DUT presents them.
module tb_result_collector;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  i;
        logic [1:0]  j;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] z_out;
    logic [1:0]  z_i;
    logic [1:0]  z_j;
    logic        z_stb;
    logic        z_ack;
    logic [31:0] current_element;
    logic        mult_done;
    logic [31:0] out_data;
    logic [1:0]  out_i;
    logic [1:0]  out_j;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] wr_count;
    logic        done;

    int          checks;
    int          passes;
    int          beatCount;
    logic [31:0] refMem [16];
    int          refCount;
    beat_t       expQ [$];

    logic        prevHeld;
    logic [31:0] heldData;
    logic [1:0]  heldI;
    logic [1:0]  heldJ;

    result_collector #(.m(4), .m_len(2), .W(32), .CW(16)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .z_out(z_out),
        .z_i(z_i),
        .z_j(z_j),
        .z_stb(z_stb),
        .z_ack(z_ack),
        .current_element(current_element),
        .mult_done(mult_done),
        .out_data(out_data),
        .out_i(out_i),
        .out_j(out_j),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .wr_count(wr_count),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: sampled on negedge, so valid&ready here is the handshake at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (prevHeld && out_valid) begin
                checkOutput("holdData", out_data, heldData);
                checkOutput("holdI", 32'(out_i), 32'(heldI));
                checkOutput("holdJ", 32'(out_j), 32'(heldJ));
            end
            if (out_valid) begin
                checkOutput("noDoneWhileValid", 32'(done), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", 32'(expQ.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beatData", out_data, e.data);
                    checkOutput("beatI", 32'(out_i), 32'(e.i));
                    checkOutput("beatJ", 32'(out_j), 32'(e.j));
                end
                beatCount++;
            end
            prevHeld = out_valid && !out_ready;
            heldData = out_data;
            heldI    = out_i;
            heldJ    = out_j;
        end else begin
            prevHeld = 1'b0;
        end
    end

    task automatic modelClear();
        for (int k = 0; k < 16; k++) refMem[k] = 32'd0;
        refCount = 0;
    endtask

    task automatic pulseClear();
        clear     = 1'b1;
        mult_done = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        modelClear();
        expQ.delete();
        checkOutput("clearValid", 32'(out_valid), 32'd0);
        checkOutput("clearDone", 32'(done), 32'd0);
        checkOutput("clearCount", 32'(wr_count), 32'd0);
    endtask

    // Hold the strobe for 'hold' cycles; the model accepts only while no ack is outstanding.
    task automatic applyStimulus(input int i, input int j, input logic [31:0] v, input int hold);
        logic ackModel;
        ackModel = 1'b0;
        z_i   = 2'(i);
        z_j   = 2'(j);
        z_out = v;
        z_stb = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            if (!ackModel) begin
                refMem[i*4+j] = v;
                if (refCount < 65535) refCount++;
                ackModel = 1'b1;
            end else begin
                ackModel = 1'b0;
            end
            checkOutput("zAck", 32'(z_ack), 32'(ackModel));
        end
        z_stb = 1'b0;
        @(posedge clk); #1;
        checkOutput("zAckLow", 32'(z_ack), 32'd0);
    endtask

    task automatic checkCell(input int i, input int j);
        z_stb = 1'b0;
        z_i   = 2'(i);
        z_j   = 2'(j);
        #1;
        checkOutput($sformatf("cell%0d%0d", i, j), current_element, refMem[i*4+j]);
    endtask

    task automatic fillMatrix(input bit patterned, input int skip);
        for (int k = 0; k < 16; k++) begin
            if (k != skip) begin
                applyStimulus(k / 4, k % 4, patterned ? 32'(16*(k/4) + (k%4)) : $urandom(),
                              int'($urandom_range(1, 2)));
            end
        end
        checkOutput("fillCount", 32'(wr_count), 32'(refCount));
    endtask

    task automatic pushExpected();
        beat_t e;
        beatCount = 0;
        for (int k = 0; k < 16; k++) begin
            e.data = refMem[k];
            e.i    = 2'(k / 4);
            e.j    = 2'(k % 4);
            expQ.push_back(e);
        end
        mult_done = 1'b1;
    endtask

    // readyMode 0: always ready, 1: pattern 1,0,0 repeating, 2: random.
    task automatic runDrain(input int readyMode, input int stopAfter);
        int cyc;
        cyc = 0;
        while (cyc < 300) begin
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            cyc++;
            if (stopAfter > 0 && beatCount >= stopAfter) break;
            if (stopAfter == 0 && done) break;
        end
        if (stopAfter == 0) begin
            checkOutput("drainDone", 32'(done), 32'd1);
            checkOutput("drainValidLow", 32'(out_valid), 32'd0);
            checkOutput("drainBeats", 32'(beatCount), 32'd16);
            checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
            mult_done = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            checkOutput("doneHeld", 32'(done), 32'd1);
        end else begin
            checkOutput("partialBeats", 32'(beatCount), 32'(stopAfter));
        end
    endtask

    initial begin
        logic [31:0] v;
        checks    = 0;
        passes    = 0;
        beatCount = 0;
        prevHeld  = 1'b0;
        rst       = 1'b1;
        clear     = 1'b0;
        z_out     = 32'd0;
        z_i       = 2'd0;
        z_j       = 2'd0;
        z_stb     = 1'b0;
        mult_done = 1'b0;
        out_ready = 1'b0;
        modelClear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rstAck", 32'(z_ack), 32'd0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstCount", 32'(wr_count), 32'd0);
        checkOutput("rstData", out_data, 32'd0);
        checkOutput("rstI", 32'(out_i), 32'd0);
        checkOutput("rstJ", 32'(out_j), 32'd0);
        checkCell(3, 3);

        $display("[TB] single write with held strobe");
        applyStimulus(1, 2, 32'h3F800000, 2);
        checkOutput("singleCount", 32'(wr_count), 32'd1);
        checkCell(1, 2);
        checkCell(1, 1);
        checkCell(2, 2);
        checkCell(0, 0);

        $display("[TB] overwrite same address");
        pulseClear();
        applyStimulus(0, 0, 32'h3F800000, 1);
        applyStimulus(0, 0, 32'h40000000, 1);
        applyStimulus(0, 0, 32'h40400000, 1);
        checkOutput("overwriteCount", 32'(wr_count), 32'd3);
        checkCell(0, 0);
        checkCell(1, 2);

        $display("[TB] patterned drain, always ready");
        pulseClear();
        fillMatrix(1'b1, -1);
        pushExpected();
        runDrain(0, 0);

        $display("[TB] patterned drain, ready 1,0,0");
        pulseClear();
        fillMatrix(1'b1, -1);
        pushExpected();
        runDrain(1, 0);

        $display("[TB] random data, random ready");
        pulseClear();
        fillMatrix(1'b0, -1);
        pushExpected();
        runDrain(2, 0);

        $display("[TB] strobe coincides with mult_done");
        pulseClear();
        fillMatrix(1'b0, 9);
        v         = $urandom();
        z_i       = 2'd2;
        z_j       = 2'd1;
        z_out     = v;
        z_stb     = 1'b1;
        mult_done = 1'b1;
        @(posedge clk); #1;
        refMem[9] = v;
        refCount++;
        checkOutput("coincideAck", 32'(z_ack), 32'd1);
        checkOutput("coincideCount", 32'(wr_count), 32'(refCount));
        checkOutput("coincideNoValid", 32'(out_valid), 32'd0);
        z_stb = 1'b0;
        pushExpected();
        runDrain(0, 0);

        $display("[TB] clear in the middle of drain");
        pulseClear();
        fillMatrix(1'b0, -1);
        pushExpected();
        runDrain(0, 5);
        pulseClear();
        for (int k = 0; k < 16; k++) checkCell(k / 4, k % 4);
        applyStimulus(3, 3, 32'hA5A5_0F0F, 1);
        checkOutput("afterClearCount", 32'(wr_count), 32'd1);
        checkCell(3, 3);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
